// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, encodings, state enum and EX/MEM entry layout
package riscv_pkg;

    localparam int DEF_DPW = 32;
    localparam int DEF_RAW = 5;

    // Control bits sit at the top of every packed entry: regwrite, memwrite, resultsrc[1:0]
    localparam int CTRL_W = 4;

    typedef enum logic [1:0] {
        RS_ALU = 2'b00,
        RS_MEM = 2'b01,
        RS_PC4 = 2'b10
    } resultsrc_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } skid_state_e;

    // Default-width view of one EX/MEM entry; the flat vectors in the datapath follow this field order
    typedef struct packed {
        logic               regwrite;
        logic               memwrite;
        logic [1:0]         resultsrc;
        logic [DEF_DPW-1:0] aluresult;
        logic [DEF_DPW-1:0] rd2;
        logic [DEF_DPW-1:0] pcplus4;
        logic [DEF_RAW-1:0] rd;
    } exmem_t;

    function automatic int entry_width(input int dpw, input int raw);
        return CTRL_W + 3 * dpw + raw;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one EX/MEM entry register with load enable and control-bit clear
module pipe_entry
    import riscv_pkg::*;
#(
    parameter int W = $bits(exmem_t)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Clear wipes only the control bits so a flushed entry can never write; data may stay stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= {{CTRL_W{1'b0}}, r_q[W-CTRL_W-1:0]};
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ex_mem_skid_reg.sv
// rtl/ex_mem_skid_reg.sv - two-entry skid register between execute and memory stages
module ex_mem_skid_reg
    import riscv_pkg::*;
#(
    parameter int DPW = DEF_DPW,
    parameter int RAW = DEF_RAW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           validE,
    output logic           readyE,
    input  logic           regwriteE,
    input  logic           memwriteE,
    input  logic [1:0]     resultsrcE,
    input  logic [DPW-1:0] aluresultE,
    input  logic [DPW-1:0] Rd2E,
    input  logic [DPW-1:0] pcplus4E,
    input  logic [RAW-1:0] RdE,
    output logic           validM,
    input  logic           readyM,
    output logic           regwriteM,
    output logic           memwriteM,
    output logic [1:0]     resultsrcM,
    output logic [DPW-1:0] aluresultM,
    output logic [DPW-1:0] Rd2M,
    output logic [DPW-1:0] pcplus4M,
    output logic [RAW-1:0] RdM,
    output logic [1:0]     occupancy
);

    localparam int EW = entry_width(DPW, RAW);

    skid_state_e r_state;
    skid_state_e w_next;

    logic          w_accept;
    logic          w_main_load;
    logic          w_skid_load;
    logic [EW-1:0] w_e;
    logic [EW-1:0] w_main_d;
    logic [EW-1:0] w_main_q;
    logic [EW-1:0] w_skid_q;
    logic          w_regwrite_q;
    logic          w_memwrite_q;

    assign w_e      = {regwriteE, memwriteE, resultsrcE, aluresultE, Rd2E, pcplus4E, RdE};
    assign readyE   = (r_state != ST_FULL);
    assign w_accept = validE && readyE && !flush;
    // Only a FULL drain refills main from skid; every other main load comes from execute
    assign w_main_d = (r_state == ST_FULL) ? w_skid_q : w_e;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and entry load enables; flush overrides every transfer
    always_comb begin
        w_next      = r_state;
        w_main_load = 1'b0;
        w_skid_load = 1'b0;
        if (flush) begin
            w_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_next      = ST_ONE;
                        w_main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && readyM) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        w_next      = ST_FULL;
                        w_skid_load = 1'b1;
                    end else if (readyM) begin
                        w_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (readyM) begin
                        w_next      = ST_ONE;
                        w_main_load = 1'b1;
                    end
                end
                default: w_next = ST_EMPTY;
            endcase
        end
    end

    pipe_entry #(.W(EW)) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_main_load),
        .i_clr  (flush),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    pipe_entry #(.W(EW)) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_skid_load),
        .i_clr  (flush),
        .i_d    (w_e),
        .o_q    (w_skid_q)
    );

    assign {w_regwrite_q, w_memwrite_q, resultsrcM, aluresultM, Rd2M, pcplus4M, RdM} = w_main_q;

    assign validM    = (r_state != ST_EMPTY);
    assign regwriteM = w_regwrite_q && validM;
    assign memwriteM = w_memwrite_q && validM;

    // Occupancy decoded from state
    always_comb begin
        case (r_state)
            ST_ONE:  occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb/tb_ex_mem_skid_reg.sv - randomized and directed checks of ex_mem_skid_reg against a queue model
module tb_ex_mem_skid_reg;

    typedef struct {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [4:0]  rd;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, validE, readyE, regwriteE, memwriteE, validM, readyM;
    logic        regwriteM, memwriteM;
    logic [1:0]  resultsrcE, resultsrcM, occupancy;
    logic [31:0] aluresultE, Rd2E, pcplus4E, aluresultM, Rd2M, pcplus4M;
    logic [4:0]  RdE, RdM;

    logic        b_flush, b_validE, b_readyE, b_regwriteE, b_memwriteE, b_validM, b_readyM;
    logic        b_regwriteM, b_memwriteM;
    logic [1:0]  b_resultsrcE, b_resultsrcM, b_occupancy;
    logic [63:0] b_aluresultE, b_Rd2E, b_pcplus4E, b_aluresultM, b_Rd2M, b_pcplus4M;
    logic [5:0]  b_RdE, b_RdM;

    ex_mem_skid_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .validE(validE), .readyE(readyE),
        .regwriteE(regwriteE), .memwriteE(memwriteE), .resultsrcE(resultsrcE),
        .aluresultE(aluresultE), .Rd2E(Rd2E), .pcplus4E(pcplus4E), .RdE(RdE),
        .validM(validM), .readyM(readyM), .regwriteM(regwriteM), .memwriteM(memwriteM),
        .resultsrcM(resultsrcM), .aluresultM(aluresultM), .Rd2M(Rd2M), .pcplus4M(pcplus4M),
        .RdM(RdM), .occupancy(occupancy)
    );

    ex_mem_skid_reg #(.DPW(64), .RAW(6)) dut_wide (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .validE(b_validE), .readyE(b_readyE),
        .regwriteE(b_regwriteE), .memwriteE(b_memwriteE), .resultsrcE(b_resultsrcE),
        .aluresultE(b_aluresultE), .Rd2E(b_Rd2E), .pcplus4E(b_pcplus4E), .RdE(b_RdE),
        .validM(b_validM), .readyM(b_readyM), .regwriteM(b_regwriteM), .memwriteM(b_memwriteM),
        .resultsrcM(b_resultsrcM), .aluresultM(b_aluresultM), .Rd2M(b_Rd2M), .pcplus4M(b_pcplus4M),
        .RdM(b_RdM), .occupancy(b_occupancy)
    );

    ent_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every DUT output against the model queue
    task automatic check_model();
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("readyE", 64'(readyE), 64'(q.size() < 2));
        chk("validM", 64'(validM), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("regwriteM", 64'(regwriteM), 64'(q[0].rw));
            chk("memwriteM", 64'(memwriteM), 64'(q[0].mw));
            chk("resultsrcM", 64'(resultsrcM), 64'(q[0].rs));
            chk("aluresultM", 64'(aluresultM), 64'(q[0].alu));
            chk("Rd2M", 64'(Rd2M), 64'(q[0].rd2));
            chk("pcplus4M", 64'(pcplus4M), 64'(q[0].pc));
            chk("RdM", 64'(RdM), 64'(q[0].rd));
        end else begin
            chk("bubble_regwriteM", 64'(regwriteM), 64'd0);
            chk("bubble_memwriteM", 64'(memwriteM), 64'd0);
        end
    endtask

    // One clock: model applies flush / consume / accept, then outputs are checked 1ns after the edge
    task automatic step();
        ent_t e;
        logic acc, pop;
        e.rw = regwriteE; e.mw = memwriteE; e.rs = resultsrcE;
        e.alu = aluresultE; e.rd2 = Rd2E; e.pc = pcplus4E; e.rd = RdE;
        acc = validE && (q.size() < 2) && !flush;
        pop = readyM && (q.size() > 0) && !flush;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
        check_model();
    endtask

    task automatic drive(input logic v, input logic rm, input logic fl, input logic [31:0] alu);
        validE     = v;
        readyM     = rm;
        flush      = fl;
        regwriteE  = 1'($urandom);
        memwriteE  = 1'($urandom);
        resultsrcE = 2'($urandom_range(0, 2));
        aluresultE = alu;
        Rd2E       = $urandom;
        pcplus4E   = $urandom;
        RdE        = 5'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        b_flush = 1'b0; b_validE = 1'b0; b_readyM = 1'b0; b_regwriteE = 1'b0; b_memwriteE = 1'b0;
        b_resultsrcE = 2'd0; b_aluresultE = '0; b_Rd2E = '0; b_pcplus4E = '0; b_RdE = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readyE", 64'(readyE), 64'd1);
        chk("rst_validM", 64'(validM), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_aluresultM", 64'(aluresultM), 64'd0);
        chk("rst_regwriteM", 64'(regwriteM), 64'd0);
        rst_n = 1'b1;

        // Stream with readyM held high
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'(i * 16));
            step();
            chk("stream_alu", 64'(aluresultM), 64'(i * 16));
            chk("stream_occ_le1", 64'(occupancy <= 2'd1), 64'd1);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();

        // Backpressure: ONE holding 0xA, accept 0xB with readyM low
        drive(1'b1, 1'b0, 1'b0, 32'hA); step();
        drive(1'b1, 1'b0, 1'b0, 32'hB); step();
        chk("bp_readyE", 64'(readyE), 64'd0);
        chk("bp_occ", 64'(occupancy), 64'd2);
        chk("bp_first", 64'(aluresultM), 64'hA);
        drive(1'b0, 1'b1, 1'b0, 32'h0); step();
        chk("bp_second", 64'(aluresultM), 64'hB);
        step();
        chk("bp_empty", 64'(validM), 64'd0);

        // Flush while FULL with a write-carrying entry offered
        drive(1'b1, 1'b0, 1'b0, 32'h1); step();
        drive(1'b1, 1'b0, 1'b0, 32'h2); step();
        drive(1'b1, 1'b0, 1'b1, 32'h3); memwriteE = 1'b1; step();
        chk("flush_validM", 64'(validM), 64'd0);
        chk("flush_memwriteM", 64'(memwriteM), 64'd0);
        chk("flush_occ", 64'(occupancy), 64'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0); step();
        chk("flush_no_deliver", 64'(validM), 64'd0);

        // Bubble with write bits asserted but validE low
        drive(1'b0, 1'b0, 1'b0, 32'h0); regwriteE = 1'b1; memwriteE = 1'b1; step();
        chk("bubble_validM", 64'(validM), 64'd0);
        chk("bubble_rw", 64'(regwriteM), 64'd0);
        chk("bubble_mw", 64'(memwriteM), 64'd0);

        // Asynchronous reset in FULL, then first accept after release
        drive(1'b1, 1'b0, 1'b0, 32'h55); step();
        drive(1'b1, 1'b0, 1'b0, 32'h66); step();
        chk("ar_full", 64'(occupancy), 64'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_validM", 64'(validM), 64'd0);
        chk("ar_readyE", 64'(readyE), 64'd1);
        chk("ar_occ", 64'(occupancy), 64'd0);
        chk("ar_alu", 64'(aluresultM), 64'd0);
        chk("ar_pc", 64'(pcplus4M), 64'd0);
        chk("ar_rd", 64'(RdM), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h77); RdE = 5'd5; step();
        chk("ar_RdM", 64'(RdM), 64'd5);
        chk("ar_validM_after", 64'(validM), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 1'($urandom), ($urandom % 16) == 0, $urandom);
            step();
        end

        // Wide instance: 64-bit datapath and 6-bit register address
        b_validE = 1'b1; b_readyM = 1'b0; b_regwriteE = 1'b1;
        b_pcplus4E = 64'hFFFF_FFFF_FFFF_FFFC; b_RdE = 6'd63;
        b_aluresultE = {$urandom, $urandom};
        @(posedge clk);
        #1;
        b_validE = 1'b0;
        chk("wide_pc", b_pcplus4M, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wide_rd", 64'(b_RdM), 64'd63);
        chk("wide_alu", b_aluresultM, b_aluresultE);
        chk("wide_validM", 64'(b_validM), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid_reg.md
EX_MEM_SKID_REG -- requirements
Module: ex_mem_skid_reg

Interface
REQ-001 SHALL have parameter DPW, 32, datapath width of aluresult, Rd2 and pcplus4 fields.
REQ-002 SHALL have parameter RAW, 5, destination register address width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush (branch mispredict or trap).
REQ-006 SHALL have port validE  input  1  execute-side entry valid.
REQ-007 SHALL have port readyE  output  1  block can accept an entry this cycle.
REQ-008 SHALL have ports regwriteE, memwriteE  input  1 each  control bits.
REQ-009 SHALL have port resultsrcE  input  2  writeback source select.
REQ-010 SHALL have ports aluresultE, Rd2E, pcplus4E  input  DPW each  data fields.
REQ-011 SHALL have port RdE  input  RAW  destination register.
REQ-012 SHALL have port validM  output  1  memory-side entry valid.
REQ-013 SHALL have port readyM  input  1  memory stage consumes the entry this cycle.
REQ-014 SHALL have outputs regwriteM, memwriteM, resultsrcM, aluresultM, Rd2M, pcplus4M, RdM, widths matching their E counterparts.
REQ-015 SHALL have port occupancy  output  2  number of held entries (0..2).

Function
REQ-016 SHALL be a two-entry skid register: main entry drives all M outputs; skid entry absorbs one transfer while readyM is low.
REQ-017 SHALL implement states EMPTY, ONE, FULL; validM = (state != EMPTY); occupancy = 0/1/2 respectively.
REQ-018 SHALL drive readyE = (state != FULL), decoded from registered state only; no combinational path from readyM or validE to readyE.
REQ-019 SHALL accept an E entry when validE && readyE, and present it on M one cycle later when the block was EMPTY, or when it was ONE with readyM high (1-cycle latency).
REQ-020 EMPTY: accept -> ONE (main loaded); otherwise stay EMPTY.
REQ-021 ONE: accept and readyM -> ONE (main replaced); accept and !readyM -> FULL (skid loaded); !accept and readyM -> EMPTY; else hold.
REQ-022 FULL: readyM -> ONE (main <= skid); else hold; no accept possible.
REQ-023 SHALL preserve strict in-order delivery; no entry dropped or duplicated absent flush.
REQ-024 flush SHALL take priority over all transfers: next state EMPTY, both entries invalidated, validE ignored that cycle.
REQ-025 SHALL force regwriteM and memwriteM to 0 whenever validM is 0, so a bubble never writes the register file or memory.
REQ-026 On flush, stored control bits SHALL clear to 0; data fields may retain prior values.
REQ-027 M outputs SHALL remain stable while validM && !readyM.

Reset
REQ-028 On rst_n low, SHALL immediately set state EMPTY and clear all stored fields; readyE 1, validM 0, occupancy 0, all other M outputs 0.
REQ-029 Reset asserted mid-transfer SHALL discard both entries; first accept after release is the first entry delivered.

Structure
REQ-030 Shared package riscv_pkg SHALL hold DPW and RAW defaults, the resultsrc encoding, the state enum, and packed struct exmem_t of all E fields.
REQ-031 SHALL instantiate sub-module pipe_entry (exmem_t register with load enable and control clear) twice: main and skid.

Verification
REQ-032 Stream: readyM=1, validE high 4 cycles with aluresultE=0x10,0x20,0x30,0x40 -> aluresultM shows the same sequence one cycle later, occupancy never exceeds 1.
REQ-033 Backpressure: state ONE holding 0xA, readyM=0, accept 0xB -> readyE 0 next cycle, occupancy 2; readyM=1 two cycles -> M delivers 0xA then 0xB, then EMPTY.
REQ-034 Flush in FULL with validE=1, memwriteE=1 -> next cycle validM 0, memwriteM 0, occupancy 0, incoming entry not delivered.
REQ-035 Bubble: validE=0 with regwriteE=1, memwriteE=1 while EMPTY -> validM, regwriteM, memwriteM stay 0.
REQ-036 Async reset: rst_n low mid-cycle in FULL -> outputs zero before next clk edge; after release accept RdE=5 -> RdM=5 with validM 1 one cycle later.
REQ-037 Parameter sweep: DPW=64, RAW=6, pcplus4E=0xFFFF_FFFF_FFFF_FFFC, RdE=63 -> pcplus4M and RdM match bit-for-bit.
